// File: rtl/sram_fifo.sv
// Word FIFO backed by the external asynchronous SRAM through its controller.
// One memory operation is in flight at a time; the oldest word is staged in an output register.
module sram_fifo #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE_W, ISSUE_R, WAIT} state_t;

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic                last_was_write_q, last_was_write_d;
  logic                rd_need, accept, pop, full_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      wptr_q           <= '0;
      rptr_q           <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      out_data_q       <= '0;
      count_q          <= '0;
      out_valid_q      <= 1'b0;
      last_was_write_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      out_data_q       <= out_data_d;
      count_q          <= count_d;
      out_valid_q      <= out_valid_d;
      last_was_write_q <= last_was_write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept)       state_d = ISSUE_W;
        else if (rd_need) state_d = ISSUE_R;
      end
      ISSUE_W, ISSUE_R:   state_d = WAIT;
      WAIT: if (mem_ready) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d           = wptr_q;
    rptr_d           = rptr_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    out_data_d       = out_data_q;
    out_valid_d      = out_valid_q;
    last_was_write_d = last_was_write_q;
    count_d          = count_q;

    if (pop) out_valid_d = 1'b0;

    if (state_q == IDLE) begin
      if (accept) begin
        addr_d           = wptr_q;
        wdata_d          = in_data;
        wptr_d           = wptr_q + PTR_ONE;
        last_was_write_d = 1'b1;
      end else if (rd_need) begin
        addr_d           = rptr_q;
        rptr_d           = rptr_q + PTR_ONE;
        last_was_write_d = 1'b0;
      end
    end

    // last_was_write doubles as the op-type flag while waiting on the controller
    if (state_q == WAIT && mem_ready && !last_was_write_q) begin
      out_data_d  = mem_rdata;
      out_valid_d = 1'b1;
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    full_w  = (count_q == DEPTH);
    rd_need = (state_q == IDLE) && !out_valid_q && (count_q != '0);
    // Reset is synchronous, so the registers alone cannot hold in_ready low during it
    in_ready    = !reset && (state_q == IDLE) && !full_w && !(rd_need && last_was_write_q);
    accept      = in_valid && in_ready;
    pop         = out_valid_q && out_ready;
    full        = full_w;
    empty       = (count_q == '0);
    count       = count_q;
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    mem_write   = (state_q == ISSUE_W);
    mem_read    = (state_q == ISSUE_R);
    mem_address = addr_q;
    mem_wdata   = wdata_q;
  end

endmodule

// File: tb/tb_sram_fifo.sv
// Bench for sram_fifo with an 8-word SRAM: a queue scoreboard, a simple controller/SRAM
// model, a vector table for fill/drain, and hand sequences for latency, wrap, and reset.
module tb_sram_fifo;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [AW:0]   count;
  logic          full, empty, mem_write, mem_read, mem_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;

  sram_fifo #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .count(count),
    .full(full), .empty(empty), .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Controller + SRAM: busy for two cycles after each request, read data only valid when idle.
  logic [DW-1:0] sram [DEPTH];
  int unsigned   busy = 0;
  assign mem_ready = (busy == 0);
  assign mem_rdata = mem_ready ? sram[mem_address] : 16'hDEAD;
  always @(posedge clk) begin
    if (reset) busy <= 0;
    else if (mem_write) begin sram[mem_address] <= mem_wdata; busy <= 2; end
    else if (mem_read) busy <= 2;
    else if (busy != 0) busy <= busy - 1;
  end

  int            vectors = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  logic [AW-1:0] exp_w = '0, exp_r = '0;
  logic [AW-1:0] wlog[$];
  int            last_op = 0, alt_viol = 0;
  bit            track_alt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: account for handshakes seen before the edge, then check state at the next negedge.
  task automatic tick();
    bit acc, pp, rst;
    logic [DW-1:0] e;
    #1;
    rst = reset;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (!rst) begin
      if (pp) begin
        if (q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL pop_nonempty: popped %0h with model empty", out_data);
        end else begin
          e = q.pop_front();
          chk("pop_data_sb", out_data, e);
        end
      end
      if (acc) q.push_back(in_data);
      chk("one_req", mem_write & mem_read, 0);
      if (mem_write) begin
        chk("waddr", mem_address, exp_w);
        wlog.push_back(mem_address);
        exp_w++;
        if (track_alt && last_op == 1) alt_viol++;
        last_op = 1;
      end
      if (mem_read) begin
        chk("raddr", mem_address, exp_r);
        exp_r++;
        if (track_alt && last_op == 2) alt_viol++;
        last_op = 2;
      end
    end
    @(negedge clk);
    if (rst) begin q.delete(); exp_w = '0; exp_r = '0; end
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("ready_when_full", in_ready & full, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_in_ready", in_ready, 0);
  endtask

  task automatic reset_dut();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check_reset_vals();
    reset = 1'b0;
    tick();
  endtask

  task automatic push(logic [DW-1:0] d);
    for (int g = 0; g < 60 && !in_ready; g++) tick();
    chk("push_wait", in_ready, 1);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(logic [DW-1:0] d);
    for (int g = 0; g < 60 && !out_valid; g++) tick();
    chk("pop_wait", out_valid, 1);
    chk("pop_data", out_data, d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int g = 0; g < 400 && q.size() != 0; g++) tick();
    out_ready = 1'b0;
    chk("drained", q.size(), 0);
    chk("drained_count", count, 0);
  endtask

  typedef struct {
    bit            is_push;
    logic [DW-1:0] data;
    int unsigned   exp_count;
    bit            exp_full;
    bit            exp_empty;
  } vec_t;

  vec_t          tbl[16];
  logic [AW-1:0] wexp[5];
  int            wr_k, rd_k, ov_k, sent;
  logic [AW-1:0] wr_a, rd_a;
  logic [DW-1:0] wr_d;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{1'b1, 16'(i + 1), 32'(i + 1), (i == 7), 1'b0};
      tbl[8 + i] = '{1'b0, 16'(i + 1), 32'(7 - i), 1'b0, (i == 7)};
    end
    wexp[0] = 3'd6; wexp[1] = 3'd7; wexp[2] = 3'd0; wexp[3] = 3'd1; wexp[4] = 3'd2;

    // Reset and idle.
    @(negedge clk);
    chk("rst_in_ready_early", in_ready, 0);
    tick();
    check_reset_vals();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_mem_req", mem_write | mem_read, 0);
    end

    // Single word into an empty FIFO: request timing and 10-cycle latency.
    chk("lat_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    wr_k = 0; rd_k = 0; ov_k = 0; wr_a = '1; rd_a = '1; wr_d = '0;
    for (int k = 1; k <= 14; k++) begin
      if (mem_write && wr_k == 0) begin wr_k = k; wr_a = mem_address; wr_d = mem_wdata; end
      if (mem_read && rd_k == 0) begin rd_k = k; rd_a = mem_address; end
      if (out_valid && ov_k == 0) ov_k = k;
      tick();
    end
    chk("lat_write_cycle", wr_k, 1);
    chk("lat_write_addr", wr_a, 0);
    chk("lat_write_data", wr_d, 16'h1234);
    chk("lat_read_cycle", rd_k, 6);
    chk("lat_read_addr", rd_a, 0);
    chk("lat_out_valid_cycle", ov_k, 10);
    chk("lat_out_data", out_data, 16'h1234);
    chk("lat_count", count, 1);
    pop_chk(16'h1234);

    // Fill to full then drain in order.
    reset_dut();
    foreach (tbl[i]) begin
      if (tbl[i].is_push) push(tbl[i].data);
      else pop_chk(tbl[i].data);
      chk("tbl_count", count, tbl[i].exp_count);
      chk("tbl_full", full, tbl[i].exp_full);
      chk("tbl_empty", empty, tbl[i].exp_empty);
      if (tbl[i].exp_full) chk("tbl_full_in_ready", in_ready, 0);
    end

    // Pop while full with in_valid held: no accept on that edge.
    reset_dut();
    for (int i = 0; i < 8; i++) push(16'h0300 + 16'(i));
    for (int g = 0; g < 60 && !out_valid; g++) tick();
    chk("fullpop_full", full, 1);
    in_valid = 1'b1; in_data = 16'h03FF; out_ready = 1'b1;
    chk("fullpop_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", count, 7);
    drain();

    // Pointer wrap-around.
    reset_dut();
    for (int i = 0; i < 6; i++) push(16'h0100 + 16'(i));
    for (int i = 0; i < 6; i++) pop_chk(16'h0100 + 16'(i));
    wlog.delete();
    for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i));
    for (int i = 0; i < 5; i++) pop_chk(16'h0200 + 16'(i));
    chk("wrap_nwrites", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) chk("wrap_addr", wlog[i], wexp[i]);

    // Continuous input, consumer always ready: ops alternate, nothing lost.
    reset_dut();
    last_op = 0; alt_viol = 0; track_alt = 1;
    in_valid = 1'b1; in_data = 16'($urandom()); out_ready = 1'b1; sent = 0;
    for (int g = 0; g < 3000 && sent < 100; g++) begin
      bit a;
      a = in_ready;
      tick();
      if (a) begin sent++; in_data = 16'($urandom()); end
    end
    in_valid = 1'b0;
    track_alt = 0;
    chk("stream_sent", sent, 100);
    chk("stream_alternate", alt_viol, 0);
    drain();

    // Random valid/ready on both sides.
    for (int g = 0; g < 500; g++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 16'($urandom());
      out_ready = 1'($urandom_range(0, 3) == 0);
      tick();
    end
    drain();

    // Reset during WAIT of a write with three words held.
    reset_dut();
    push(16'hBEEF); push(16'h2222); push(16'h3333);
    chk("mw_issue", mem_write, 1);
    tick();
    chk("mw_count", count, 3);
    chk("mw_out_valid", out_valid, 1);
    chk("mw_busy", mem_ready, 0);
    reset = 1'b1;
    tick();
    check_reset_vals();
    reset = 1'b0;
    tick();
    chk("mw_after_in_ready", in_ready, 1);
    chk("mw_after_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
